// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register, one-entry skid buffer.
// Optional delivered-instruction counter enabled by defining FETCH_CNT_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_offset,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic [31:0] if_inst,
    output logic [63:0] if_pc,
    output logic        if_valid,
    output logic [31:0] fetch_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DROP = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic        load_if;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_inst_d   = if_inst_q;
        if_pc_d     = if_pc_q;
        if_valid_d  = if_valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        load_if     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = branch_taken ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (imem_valid) begin
                    state_d = S_REQ;
                    if (!branch_taken && !stall) begin
                        if_inst_d  = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        load_if    = 1'b1;
                        pc_d       = pc_q + 64'd4;
                    end else if (!branch_taken) begin
                        skid_inst_d = imem_rdata;
                        skid_pc_d   = pc_q;
                        pc_d        = pc_q + 64'd4;
                        state_d     = S_HOLD;
                    end
                end else if (branch_taken) begin
                    state_d = S_DROP;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                end
            end
            S_DROP: begin
                if (imem_valid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    if_inst_d  = skid_inst_q;
                    if_pc_d    = skid_pc_q;
                    if_valid_d = 1'b1;
                    load_if    = 1'b1;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect wins over stall and over any same-cycle response; leaving S_HOLD drops the skid.
        if (branch_taken && (state_q != S_IDLE)) begin
            pc_d       = if_pc_q + branch_offset;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            if_valid_q  <= 1'b0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_inst_q   <= if_inst_d;
            if_pc_q     <= if_pc_d;
            if_valid_q  <= if_valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_inst   = if_inst_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;

`ifdef FETCH_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    always_comb begin
        fetch_count_d = load_if ? (fetch_count_q + 32'd1) : fetch_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    logic unused_load_if;
    assign unused_load_if = load_if;
    assign fetch_count    = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences,
// and a randomized run against a flag-based reference model with a variable-latency memory.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_offset;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        if_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .fetch_count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [63:0] off;
        logic        mv;
        logic [31:0] rd;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        int          e_n;
    } vec_t;

    vec_t vecs[$];

    // Reference model: fetcher described by occupancy flags instead of named states.
    logic        m_idle, m_out, m_drop, m_skid_v, m_if_valid;
    logic [63:0] m_pc, m_if_pc, m_skid_pc;
    logic [31:0] m_if_inst, m_skid_inst, m_cnt;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] expCnt(input logic [31:0] n);
`ifdef FETCH_CNT_EN
        return n;
`else
        return n & 32'd0;
`endif
    endfunction

    function automatic vec_t mkVec(input logic st, input logic br, input logic [63:0] off,
                                   input logic mv, input logic [31:0] rd, input logic e_req,
                                   input logic [63:0] e_addr, input logic e_valid,
                                   input logic [63:0] e_pc, input logic [31:0] e_inst,
                                   input int e_n);
        vec_t v;
        v.st = st; v.br = br; v.off = off; v.mv = mv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_inst = e_inst; v.e_n = e_n;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic br, input logic [63:0] off,
                                 input logic mv, input logic [31:0] rd);
        reset         = 1'b0;
        stall         = st;
        branch_taken  = br;
        branch_offset = off;
        imem_valid    = mv;
        imem_rdata    = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut(input logic st, input logic br, input logic mv);
        reset         = 1'b1;
        stall         = st;
        branch_taken  = br;
        branch_offset = 64'hFFFF_FFFF_FFFF_FFF0;
        imem_valid    = mv;
        imem_rdata    = 32'hDEAD_DEAD;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic deliverOne(input logic [63:0] a);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b0, 32'hDEAD_DEAD);
        applyStimulus(1'b0, 1'b0, 64'd0, 1'b1, memWord(a));
    endtask

    task automatic modelStep(input logic rst, input logic st, input logic br,
                             input logic [63:0] off, input logic mv, input logic [31:0] rd);
        logic issue;
        if (rst) begin
            m_idle = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_skid_v = 1'b0;
            m_pc = '0; m_if_pc = '0; m_if_inst = '0; m_if_valid = 1'b0;
            m_skid_pc = '0; m_skid_inst = '0; m_cnt = '0;
            return;
        end
        if (m_idle) begin
            m_idle = 1'b0;
            return;
        end
        issue = !m_out && !m_skid_v;
        if (br) begin
            m_pc       = m_if_pc + off;
            m_if_valid = 1'b0;
            m_skid_v   = 1'b0;
            if (issue) begin
                m_out = 1'b1; m_drop = 1'b1;
            end else if (m_out) begin
                if (mv) begin m_out = 1'b0; m_drop = 1'b0; end
                else m_drop = 1'b1;
            end
        end else if (issue) begin
            m_out = 1'b1; m_drop = 1'b0;
        end else if (m_out) begin
            if (mv) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                end else if (!st) begin
                    m_if_inst = rd; m_if_pc = m_pc; m_if_valid = 1'b1;
                    m_cnt = m_cnt + 32'd1;
                    m_pc = m_pc + 64'd4;
                end else begin
                    m_skid_inst = rd; m_skid_pc = m_pc; m_skid_v = 1'b1;
                    m_pc = m_pc + 64'd4;
                end
                m_out = 1'b0;
            end else if (!m_drop && !st) begin
                m_if_valid = 1'b0;
            end
        end else if (!st) begin
            m_if_inst = m_skid_inst; m_if_pc = m_skid_pc; m_if_valid = 1'b1;
            m_skid_v = 1'b0;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] d[0:6];
        logic [31:0] junk;
        logic [63:0] wrap_pc;
        logic        mem_pend;
        int          mem_cnt;
        logic [63:0] mem_addr;
        logic        r_st, r_br, r_mv, r_rst, m_issue;
        logic [63:0] r_off;
        logic [31:0] r_rd, hi, lo;

        junk    = 32'hDEAD_DEAD;
        wrap_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        for (int i = 0; i < 7; i++) d[i] = 32'h1000_0000 + 32'(i * 32'h0101_0011);

        stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        imem_valid = 1'b0; imem_rdata = '0; reset = 1'b1;

        // Reset with every input active must still produce a clean, idle fetcher.
        resetDut(1'b1, 1'b1, 1'b1);
        checkOutput("rst_req", imem_req, 1'b0);
        checkOutput("rst_addr", imem_addr, 64'd0);
        checkOutput("rst_valid", if_valid, 1'b0);
        checkOutput("rst_pc", if_pc, 64'd0);
        checkOutput("rst_inst", if_inst, 32'd0);
        checkOutput("rst_cnt", fetch_count, 32'd0);

        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 1, 64'h0,   0, 64'h0,  32'd0, 0));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h0,   0, 64'h0,  32'd0, 0));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[0], 1, 64'h4,   1, 64'h0,  d[0],  1));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h4,   1, 64'h0,  d[0],  1));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[1], 1, 64'h8,   1, 64'h4,  d[1],  2));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h8,   1, 64'h4,  d[1],  2));
        vecs.push_back(mkVec(1, 0, 64'd0, 1, d[2], 0, 64'hC,   1, 64'h4,  d[1],  2));
        vecs.push_back(mkVec(1, 0, 64'd0, 0, junk, 0, 64'hC,   1, 64'h4,  d[1],  2));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 1, 64'hC,   1, 64'h8,  d[2],  3));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'hC,   1, 64'h8,  d[2],  3));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[3], 1, 64'h10,  1, 64'hC,  d[3],  4));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h10,  1, 64'hC,  d[3],  4));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[4], 1, 64'h14,  1, 64'h10, d[4],  5));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h14,  1, 64'h10, d[4],  5));
        vecs.push_back(mkVec(0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0, junk, 0, 64'h0, 0, 64'h10, d[4], 5));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[5], 1, 64'h0,   0, 64'h10, d[4],  5));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h0,   0, 64'h10, d[4],  5));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[0], 1, 64'h4,   1, 64'h0,  d[0],  6));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h4,   1, 64'h0,  d[0],  6));
        vecs.push_back(mkVec(0, 1, 64'h100, 1, d[1], 1, 64'h100, 0, 64'h0, d[0],  6));
        vecs.push_back(mkVec(0, 0, 64'd0, 0, junk, 0, 64'h100, 0, 64'h0,  d[0],  6));
        vecs.push_back(mkVec(0, 0, 64'd0, 1, d[6], 1, 64'h104, 1, 64'h100, d[6], 7));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].st, vecs[i].br, vecs[i].off, vecs[i].mv, vecs[i].rd);
            checkOutput($sformatf("tbl%0d_req", i), imem_req, vecs[i].e_req);
            checkOutput($sformatf("tbl%0d_addr", i), imem_addr, vecs[i].e_addr);
            checkOutput($sformatf("tbl%0d_valid", i), if_valid, vecs[i].e_valid);
            checkOutput($sformatf("tbl%0d_pc", i), if_pc, vecs[i].e_pc);
            checkOutput($sformatf("tbl%0d_inst", i), if_inst, vecs[i].e_inst);
            checkOutput($sformatf("tbl%0d_cnt", i), fetch_count, expCnt(32'(vecs[i].e_n)));
        end

        // PC wrap at the top of the address space, then count five deliveries around one redirect.
        resetDut(1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 64'd0, 0, junk);
        checkOutput("wrap_first_req", imem_req, 1'b1);
        applyStimulus(0, 0, 64'd0, 0, junk);
        applyStimulus(0, 0, 64'd0, 1, memWord(64'd0));
        checkOutput("wrap_w0_pc", if_pc, 64'd0);
        applyStimulus(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, junk);
        checkOutput("wrap_br_req", imem_req, 1'b0);
        checkOutput("wrap_br_addr", imem_addr, wrap_pc);
        checkOutput("wrap_br_valid", if_valid, 1'b0);
        applyStimulus(0, 0, 64'd0, 1, memWord(64'd4));
        checkOutput("wrap_drop_req", imem_req, 1'b1);
        checkOutput("wrap_drop_addr", imem_addr, wrap_pc);
        checkOutput("wrap_drop_valid", if_valid, 1'b0);
        applyStimulus(0, 0, 64'd0, 0, junk);
        applyStimulus(0, 0, 64'd0, 1, memWord(wrap_pc));
        checkOutput("wrap_top_pc", if_pc, wrap_pc);
        checkOutput("wrap_top_inst", if_inst, memWord(wrap_pc));
        checkOutput("wrap_next_req", imem_req, 1'b1);
        checkOutput("wrap_next_addr", imem_addr, 64'd0);
        deliverOne(64'd0);
        deliverOne(64'd4);
        deliverOne(64'd8);
        checkOutput("cnt5_pc", if_pc, 64'd8);
        checkOutput("cnt5_cnt", fetch_count, expCnt(32'd5));

        // Randomized run with a 1..3 cycle memory and occasional mid-operation resets.
        resetDut(1'b0, 1'b0, 1'b0);
        modelStep(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 32'd0);
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_issue = !m_idle && !m_out && !m_skid_v;
            checkOutput("rnd_req", imem_req, m_issue);
            if (m_issue) checkOutput("rnd_addr", imem_addr, m_pc);

            r_mv = 1'b0;
            r_rd = $urandom;
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    r_mv = 1'b1;
                    r_rd = memWord(mem_addr);
                    mem_pend = 1'b0;
                end
            end
            if (imem_req) begin
                mem_pend = 1'b1;
                mem_cnt  = int'($urandom_range(1, 3));
                mem_addr = imem_addr;
            end

            r_st  = ($urandom_range(0, 9) < 3);
            r_br  = ($urandom_range(0, 11) == 0);
            r_rst = ($urandom_range(0, 149) == 0);
            case ($urandom_range(0, 3))
                0: begin hi = $urandom; lo = $urandom; r_off = {hi, lo} & ~64'd3; end
                1: r_off = -(64'($urandom_range(1, 64)) << 2);
                default: r_off = 64'($urandom_range(0, 64)) << 2;
            endcase

            applyStimulus(r_st, r_br, r_off, r_mv, r_rd);
            if (r_rst) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                mem_pend = 1'b0;
            end
            modelStep(r_rst, r_st, r_br, r_off, r_mv, r_rd);

            checkOutput("rnd_valid", if_valid, m_if_valid);
            checkOutput("rnd_pc", if_pc, m_if_pc);
            checkOutput("rnd_inst", if_inst, m_if_inst);
            checkOutput("rnd_cnt", fetch_count, expCnt(m_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high: clk, reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on the clk rising edge.
REQ-004 stall  input  1  decode cannot accept; hold the IF/ID register.
REQ-005 branch_taken  input  1  redirect request from decode for the instruction in IF/ID.
REQ-006 branch_offset  input  64  sign-extended, already <<2, from the sign-extension unit.
REQ-007 imem_rdata  input  32  instruction word; valid only when imem_valid=1.
REQ-008 imem_valid  input  1  one-cycle response strobe, at least 1 cycle after imem_req.
REQ-009 imem_req  output  1  one-cycle request pulse; the memory always accepts it.
REQ-010 imem_addr  output  64  request address, equal to pc.
REQ-011 if_inst  output  32  IF/ID instruction, to the decoder and sign-extension unit.
REQ-012 if_pc  output  64  IF/ID PC of if_inst.
REQ-013 if_valid  output  1  IF/ID holds a live instruction.
REQ-014 fetch_count  output  32  delivered-instruction counter (see Configuration).

Function
REQ-015 States SHALL be S_IDLE, S_REQ, S_WAIT, S_DROP, S_HOLD; at most one request SHALL be outstanding.
REQ-016 S_IDLE: next S_REQ unconditionally; imem_valid is ignored.
REQ-017 S_REQ: imem_req=1 for one cycle; next S_WAIT, or S_DROP when branch_taken=1 in that cycle.
REQ-018 S_WAIT with imem_valid=1 and stall=0: if_inst<=imem_rdata; if_pc<=pc; if_valid<=1; pc<=pc+4; next S_REQ.
REQ-019 S_WAIT with imem_valid=1 and stall=1: the word and pc go to a one-entry skid buffer; pc<=pc+4; next S_HOLD; IF/ID is unchanged.
REQ-020 S_WAIT without imem_valid: stay; if stall=0, if_valid<=0.
REQ-021 S_HOLD: when stall=0, IF/ID<=skid with if_valid<=1 and next S_REQ; while stall=1, stay with no request.
REQ-022 S_DROP: imem_valid discards the response and goes to S_REQ; branch_taken in S_DROP updates pc and stays in S_DROP.
REQ-023 Redirect (branch_taken=1, any state except S_IDLE) SHALL:
- set pc<=if_pc+branch_offset, mod 2^64 with wrap and no overflow flag;
- set if_valid<=0;
- discard the skid buffer.
REQ-024 Redirect has priority over stall and over a same-cycle imem_valid; that response is discarded and the next state is S_REQ.
REQ-025 Redirect in S_WAIT without imem_valid SHALL go to S_DROP.
REQ-026 pc+4 and branch arithmetic are 64-bit unsigned wrap: pc=FFFF_FFFF_FFFF_FFFC advances to 0.
REQ-027 imem_addr SHALL be stable throughout S_REQ; if_inst/if_pc SHALL hold while stall=1.
REQ-028 Delivery latency: a word received at edge N with stall=0 SHALL be visible on if_inst after edge N.

Reset
REQ-029 reset=1 SHALL force, on the next edge:
- pc=0, state=S_IDLE, imem_req=0, imem_addr=0;
- if_inst=0, if_pc=0, if_valid=0;
- skid empty, fetch_count=0.
REQ-030 Reset mid-operation SHALL abandon any outstanding request; the memory is reset with the same signal.
REQ-031 The first request (addr 0) SHALL occur 2 cycles after reset deasserts.

Configuration
REQ-032 With FETCH_CNT_EN defined, fetch_count SHALL increment (wrapping) on every edge where if_valid is loaded with 1.
REQ-033 Without FETCH_CNT_EN, fetch_count SHALL be constant 0 and no counter is built.

Verification
REQ-034 Reset, memory returns D0 1 cycle after each req, stall=0 -> addresses 0,4,8; if_inst sequence D0,D1,D2; if_pc sequence 0,4,8.
REQ-035 stall=1 when the word at addr 8 returns -> state S_HOLD, IF/ID unchanged; stall=0 -> word at 8 delivered; next req addr 0xC.
REQ-036 if_pc=0x10, branch_offset=0xFFFF_FFFF_FFFF_FFF0, branch_taken=1 during S_WAIT -> late response discarded; next req addr 0x0; if_valid=0.
REQ-037 branch_taken and imem_valid in the same cycle -> word discarded; next req to target; if_valid=0.
REQ-038 pc=0xFFFF_FFFF_FFFF_FFFC fetched -> next req addr 0.
REQ-039 FETCH_CNT_EN defined, 5 words delivered with one redirect -> fetch_count=5; undefined -> fetch_count=0.
